// File: rtl/mouse_pkg.sv
// -----------------------------------------------------------------------------
// mouse_pkg
// Shared definitions for the PS/2 mouse master sequencer:
//   - master_state_t : 4-bit state encoding (also exported on MASTER_STATE)
//   - PS/2 command bytes (reset, enable streaming)
//   - PS/2 response bytes (ACK, BAT passed, standard mouse device ID)
//   - helper functions that classify states
// -----------------------------------------------------------------------------
package mouse_pkg;

  localparam int unsigned CNT_WIDTH = 24;

  typedef enum logic [3:0] {
    ST_INIT_WAIT        = 4'd0,
    ST_SEND_RESET       = 4'd1,
    ST_WAIT_RESET_SENT  = 4'd2,
    ST_WAIT_ACK1        = 4'd3,
    ST_WAIT_BAT         = 4'd4,
    ST_WAIT_ID          = 4'd5,
    ST_SEND_ENABLE      = 4'd6,
    ST_WAIT_ENABLE_SENT = 4'd7,
    ST_WAIT_ACK2        = 4'd8,
    ST_RX_STATUS        = 4'd9,
    ST_RX_DX            = 4'd10,
    ST_RX_DY            = 4'd11
  } master_state_t;

  localparam logic [7:0] CMD_RESET         = 8'hFF;
  localparam logic [7:0] CMD_ENABLE_STREAM = 8'hF4;

  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] RSP_DEVICE_ID = 8'h00;

  // States in which the receiver is enabled and BYTE_READY is honoured.
  function automatic logic is_rx_state(input master_state_t s);
    logic r;
    r = 1'b0;
    case (s)
      ST_WAIT_ACK1, ST_WAIT_BAT, ST_WAIT_ID,
      ST_WAIT_ACK2, ST_RX_STATUS, ST_RX_DX, ST_RX_DY: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Handshake-waiting states covered by the response watchdog.
  // Streaming states are deliberately excluded: a still mouse sends nothing.
  function automatic logic is_watched_state(input master_state_t s);
    logic r;
    r = 1'b0;
    case (s)
      ST_WAIT_RESET_SENT, ST_WAIT_ACK1, ST_WAIT_BAT, ST_WAIT_ID,
      ST_WAIT_ENABLE_SENT, ST_WAIT_ACK2: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mouse_delay_counter.sv
// -----------------------------------------------------------------------------
// mouse_delay_counter
// Free-running up-counter with synchronous clear and a terminal-count compare.
// Shared by the power-up wait and the response watchdog of mouse_master_sm.
// The count saturates at all-ones so an indefinite wait never wraps back into
// a spurious terminal-count match.
//
// Ports:
//   CLK          in   system clock
//   RESET        in   asynchronous, active-high reset (count -> 0)
//   i_clear      in   synchronous clear (count -> 0 on next edge)
//   i_terminal   in   WIDTH  compare value
//   o_terminal   out  1 while count == i_terminal
// -----------------------------------------------------------------------------
module mouse_delay_counter #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_terminal,
  output logic             o_terminal
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != {WIDTH{1'b1}}) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == i_terminal);

endmodule

// File: rtl/mouse_master_sm.sv
// -----------------------------------------------------------------------------
// mouse_master_sm
// Sequencing controller for a PS/2 mouse. Performs power-up initialisation
// (wait, send FF, expect FA/AA/00, send F4, expect FA) and then assembles
// 3-byte movement packets into MOUSE_STATUS/DX/DY with a one-cycle
// SEND_INTERRUPT per complete packet.
//
// Optional feature macro: MOUSE_MASTER_WATCHDOG_EN
//   defined   : handshake-waiting states (2..5, 7, 8) return to INIT_WAIT when
//               the shared counter reaches RESP_TIMEOUT_CYCLES-1.
//   undefined : those states wait indefinitely.
//
// Parameters:
//   INIT_WAIT_CYCLES     power-up delay before the reset command (1..2^24-1)
//   RESP_TIMEOUT_CYCLES  per-state response timeout (1..2^24-1, watchdog only)
//
// Ports:
//   CLK              in   system clock
//   RESET            in   asynchronous, active-high
//   SEND_BYTE        out  one-cycle transmit request
//   BYTE_TO_SEND     out  8  command byte, held until the next command
//   BYTE_SENT        in   one-cycle transmit-done
//   READ_ENABLE      out  receiver enable
//   BYTE_READ        in   8  received byte
//   BYTE_ERROR_CODE  in   2  00 = clean byte
//   BYTE_READY       in   one-cycle receive-done
//   MOUSE_STATUS     out  8  packet byte 0
//   MOUSE_DX         out  8  packet byte 1
//   MOUSE_DY         out  8  packet byte 2
//   SEND_INTERRUPT   out  one-cycle new-packet pulse
//   MASTER_STATE     out  4  current state (debug)
// -----------------------------------------------------------------------------
module mouse_master_sm
  import mouse_pkg::*;
#(
  parameter int unsigned INIT_WAIT_CYCLES    = 1_000_000,
  parameter int unsigned RESP_TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic [3:0] MASTER_STATE
);

  localparam logic [CNT_WIDTH-1:0] INIT_TERM = CNT_WIDTH'(INIT_WAIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RESP_TERM = CNT_WIDTH'(RESP_TIMEOUT_CYCLES - 1);

  master_state_t r_state;
  master_state_t w_state_next;

  logic       r_send_byte;
  logic [7:0] r_byte_to_send;
  logic       r_read_enable;
  logic [7:0] r_pkt_status;
  logic [7:0] r_pkt_dx;
  logic [7:0] r_mouse_status;
  logic [7:0] r_mouse_dx;
  logic [7:0] r_mouse_dy;
  logic       r_interrupt;

  logic                 w_clear;
  logic                 w_tc;
  logic [CNT_WIDTH-1:0] w_terminal;
  logic                 w_byte_ok;
  logic                 w_rx_ok;

  // The single counter serves two purposes: the init delay in state 0 and the
  // response timeout everywhere else, so only the compare value changes.
  assign w_terminal = (r_state == ST_INIT_WAIT) ? INIT_TERM : RESP_TERM;
  assign w_clear    = (w_state_next != r_state);

  mouse_delay_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_delay_counter (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_clear    (w_clear),
    .i_terminal (w_terminal),
    .o_terminal (w_tc)
  );

  assign w_byte_ok = (BYTE_ERROR_CODE == 2'b00);
  assign w_rx_ok   = BYTE_READY && w_byte_ok;

  // Next-state logic. BYTE_READY is only examined in receive states and
  // BYTE_SENT only in the two transmit-wait states, so stray pulses elsewhere
  // are ignored by construction.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT_WAIT:        if (w_tc) w_state_next = ST_SEND_RESET;
      ST_SEND_RESET:       w_state_next = ST_WAIT_RESET_SENT;
      ST_WAIT_RESET_SENT:  if (BYTE_SENT) w_state_next = ST_WAIT_ACK1;
      ST_WAIT_ACK1:
        if (BYTE_READY)
          w_state_next = (w_byte_ok && BYTE_READ == RSP_ACK) ? ST_WAIT_BAT : ST_INIT_WAIT;
      ST_WAIT_BAT:
        if (BYTE_READY)
          w_state_next = (w_byte_ok && BYTE_READ == RSP_BAT_OK) ? ST_WAIT_ID : ST_INIT_WAIT;
      ST_WAIT_ID:
        if (BYTE_READY)
          w_state_next = (w_byte_ok && BYTE_READ == RSP_DEVICE_ID) ? ST_SEND_ENABLE : ST_INIT_WAIT;
      ST_SEND_ENABLE:      w_state_next = ST_WAIT_ENABLE_SENT;
      ST_WAIT_ENABLE_SENT: if (BYTE_SENT) w_state_next = ST_WAIT_ACK2;
      ST_WAIT_ACK2:
        if (BYTE_READY)
          w_state_next = (w_byte_ok && BYTE_READ == RSP_ACK) ? ST_RX_STATUS : ST_INIT_WAIT;
      // Bit 3 of a status byte is always 1; anything else is treated as
      // misalignment and dropped so the stream resynchronises.
      ST_RX_STATUS:        if (w_rx_ok && BYTE_READ[3]) w_state_next = ST_RX_DX;
      ST_RX_DX:            if (BYTE_READY) w_state_next = w_byte_ok ? ST_RX_DY : ST_RX_STATUS;
      ST_RX_DY:            if (BYTE_READY) w_state_next = ST_RX_STATUS;
      default:             w_state_next = ST_INIT_WAIT;
    endcase
`ifdef MOUSE_MASTER_WATCHDOG_EN
    // Timeout has priority over a handshake arriving in the same cycle.
    if (is_watched_state(r_state) && w_tc)
      w_state_next = ST_INIT_WAIT;
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state        <= ST_INIT_WAIT;
      r_send_byte    <= 1'b0;
      r_byte_to_send <= 8'h00;
      r_read_enable  <= 1'b0;
      r_pkt_status   <= 8'h00;
      r_pkt_dx       <= 8'h00;
      r_mouse_status <= 8'h00;
      r_mouse_dx     <= 8'h00;
      r_mouse_dy     <= 8'h00;
      r_interrupt    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      // Derived from the next state so the enable lines up with MASTER_STATE.
      r_read_enable <= is_rx_state(w_state_next);
      r_send_byte   <= 1'b0;
      r_interrupt   <= 1'b0;
      case (r_state)
        ST_SEND_RESET: begin
          r_send_byte    <= 1'b1;
          r_byte_to_send <= CMD_RESET;
        end
        ST_SEND_ENABLE: begin
          r_send_byte    <= 1'b1;
          r_byte_to_send <= CMD_ENABLE_STREAM;
        end
        ST_RX_STATUS: if (w_rx_ok && BYTE_READ[3]) r_pkt_status <= BYTE_READ;
        ST_RX_DX:     if (w_rx_ok) r_pkt_dx <= BYTE_READ;
        // Host-visible outputs move only here, as a complete packet.
        ST_RX_DY: begin
          if (w_rx_ok) begin
            r_mouse_status <= r_pkt_status;
            r_mouse_dx     <= r_pkt_dx;
            r_mouse_dy     <= BYTE_READ;
            r_interrupt    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign SEND_BYTE      = r_send_byte;
  assign BYTE_TO_SEND   = r_byte_to_send;
  assign READ_ENABLE    = r_read_enable;
  assign MOUSE_STATUS   = r_mouse_status;
  assign MOUSE_DX       = r_mouse_dx;
  assign MOUSE_DY       = r_mouse_dy;
  assign SEND_INTERRUPT = r_interrupt;
  assign MASTER_STATE   = r_state;

endmodule
